// File: rtl/bcd_serial_adder.sv
// bcd_serial_adder
// Digit-serial packed-BCD adder. One BCD digit is processed per clock,
// least significant digit first, between a valid/ready input handshake
// and a valid/ready output handshake.
//
// Optional feature macro: BCD_SUB_EN
//   defined   : in_sub=1 at accept computes A-B via nines complement of B
//               plus an initial carry; out_neg flags a negative result,
//               which is then returned in tens-complement form.
//   undefined : plain addition only, in_sub ignored, out_neg tied low.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for operands, in_ready high
// RUN   | one digit per cycle, ND cycles, cnt selects progress
// DONE  | result held on out_sum/out_err/out_neg until out_ready

module bcd_serial_adder #(
   parameter int ND = 4,
   parameter int CW = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [4*ND-1:0] in_a,
   input  logic [4*ND-1:0] in_b,
   input  logic            in_sub,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [4*ND+3:0] out_sum,
   output logic            out_err,
   output logic            out_neg
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [CW-1:0] LAST_DIGIT = CW'(ND - 1);

   state_t          state_q, state_d;
   logic [4*ND-1:0] a_q, a_d;
   logic [4*ND-1:0] b_q, b_d;
   logic [4*ND-1:0] res_q, res_d;
   logic            carry_q, carry_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [4*ND+3:0] sum_q, sum_d;
   logic            err_q, err_d;

   logic [4*ND-1:0] b_acc;
   logic            carry_acc;
   logic            bad_digit;
   logic [4:0]      dsum;
   logic [3:0]      digit;
   logic            carry_nxt;
   logic [3:0]      top_digit;

`ifdef BCD_SUB_EN
   logic            sub_q, sub_d;
   logic            neg_q, neg_d;
`else
   logic            unused_sub;
   assign unused_sub = in_sub;
`endif

   // Operand preparation at accept: digit range check, optional complement of B
   always_comb begin
      bad_digit = 1'b0;
      b_acc     = in_b;
      carry_acc = 1'b0;
      for (int i = 0; i < ND; i++) begin
         if ((in_a[4*i +: 4] > 4'd9) || (in_b[4*i +: 4] > 4'd9)) begin
            bad_digit = 1'b1;
         end
`ifdef BCD_SUB_EN
         if (in_sub) begin
            b_acc[4*i +: 4] = 4'd9 - in_b[4*i +: 4];
         end
`endif
      end
`ifdef BCD_SUB_EN
      carry_acc = in_sub;
`endif
   end

   // Single-digit BCD add on the current low nibbles of the shifting operands
   always_comb begin
      dsum      = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'd0, carry_q};
      carry_nxt = (dsum > 5'd9);
      digit     = carry_nxt ? (dsum[3:0] + 4'd6) : dsum[3:0];
   end

   // Next-state and datapath update; defaults hold every register
   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      res_d     = res_q;
      carry_d   = carry_q;
      cnt_d     = cnt_q;
      sum_d     = sum_q;
      err_d     = err_q;
      top_digit = 4'd0;
`ifdef BCD_SUB_EN
      sub_d     = sub_q;
      neg_d     = neg_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_d     = in_a;
               b_d     = b_acc;
               carry_d = carry_acc;
               cnt_d   = '0;
               err_d   = bad_digit;
`ifdef BCD_SUB_EN
               sub_d   = in_sub;
`endif
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            // Operands shift right so the active digit is always in [3:0];
            // result digits enter at the top and settle into place after ND shifts.
            a_d     = a_q >> 4;
            b_d     = b_q >> 4;
            carry_d = carry_nxt;
            res_d   = res_q >> 4;
            res_d[4*ND-1 -: 4] = digit;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LAST_DIGIT) begin
`ifdef BCD_SUB_EN
               // A subtraction never reports a carry digit; the final carry
               // only decides the sign.
               top_digit = sub_q ? 4'd0 : {3'b000, carry_nxt};
               neg_d     = sub_q & ~carry_nxt & ~err_q;
`else
               top_digit = {3'b000, carry_nxt};
`endif
               sum_d   = err_q ? '0 : {top_digit, res_d};
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         err_q   <= 1'b0;
`ifdef BCD_SUB_EN
         sub_q   <= 1'b0;
         neg_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         err_q   <= err_d;
`ifdef BCD_SUB_EN
         sub_q   <= sub_d;
         neg_q   <= neg_d;
`endif
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign out_sum   = sum_q;
   assign out_err   = err_q;
`ifdef BCD_SUB_EN
   assign out_neg   = neg_q;
`else
   assign out_neg   = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Testbench for bcd_serial_adder: a table of directed operations, randomized
// operations against a decimal-arithmetic reference model, a mid-operation
// reset sequence, and an exhaustive single-digit instance run back to back.

module tb_bcd_serial_adder;

`ifdef BCD_SUB_EN
   localparam bit SUB_EN = 1'b1;
`else
   localparam bit SUB_EN = 1'b0;
`endif

   localparam int ND4 = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        in_valid = 1'b0, in_ready, in_sub = 1'b0;
   logic [15:0] in_a = '0, in_b = '0;
   logic        out_valid, out_ready = 1'b0, out_err, out_neg;
   logic [19:0] out_sum;

   logic        in_valid1 = 1'b0, in_ready1, in_sub1 = 1'b0;
   logic [3:0]  in_a1 = '0, in_b1 = '0;
   logic        out_valid1, out_ready1 = 1'b0, out_err1, out_neg1;
   logic [7:0]  out_sum1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bcd_serial_adder #(.ND(4), .CW(3)) dut4 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_err(out_err), .out_neg(out_neg)
   );

   bcd_serial_adder #(.ND(1), .CW(1)) dut1 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid1), .in_ready(in_ready1),
      .in_a(in_a1), .in_b(in_b1), .in_sub(in_sub1),
      .out_valid(out_valid1), .out_ready(out_ready1),
      .out_sum(out_sum1), .out_err(out_err1), .out_neg(out_neg1)
   );

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        sub;
      int          hold;
      logic [19:0] sum;
      logic        err;
      logic        neg;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: decode digits to integers, do decimal arithmetic, re-encode.
   function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic sub,
                                 output logic [19:0] s, output logic e, output logic n);
      int av, bv, r, p;
      e = 1'b0; n = 1'b0; s = '0;
      av = 0; bv = 0; p = 1;
      for (int i = 0; i < 4; i++) begin
         if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) e = 1'b1;
         av += int'(a[4*i +: 4]) * p;
         bv += int'(b[4*i +: 4]) * p;
         p  *= 10;
      end
      if (e) return;
      if (SUB_EN && sub) begin
         if (av >= bv) r = av - bv;
         else begin
            r = 10000 - (bv - av);
            n = 1'b1;
         end
      end else begin
         r = av + bv;
      end
      for (int i = 0; i < 5; i++) begin
         s[4*i +: 4] = 4'(r % 10);
         r = r / 10;
      end
   endfunction

   // One full operation on the 4-digit instance, with out_ready held low for
   // 'hold' cycles once the result appears.
   task automatic run4(input logic [15:0] a, input logic [15:0] b, input logic sub,
                       input int hold, input logic [19:0] es, input logic ee,
                       input logic en, input string nm);
      int lat;
      @(negedge clk);
      check({nm, " in_ready idle"}, 32'(in_ready), 32'd1);
      in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check({nm, " latency"}, 32'(lat), 32'(ND4));
      check({nm, " sum"}, 32'(out_sum), 32'(es));
      check({nm, " err"}, 32'(out_err), 32'(ee));
      check({nm, " neg"}, 32'(out_neg), 32'(en));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({nm, " held valid"}, 32'(out_valid), 32'd1);
         check({nm, " held in_ready"}, 32'(in_ready), 32'd0);
         check({nm, " held sum"}, 32'(out_sum), 32'(es));
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({nm, " valid drops"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      logic [15:0] ra, rb;
      logic        rs;
      logic [19:0] es;
      logic        ee, en;
      int          n, t, total;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst in_ready", 32'(in_ready), 32'd1);
      check("rst out_valid", 32'(out_valid), 32'd0);
      check("rst out_sum", 32'(out_sum), 32'd0);
      check("rst out_err", 32'(out_err), 32'd0);
      check("rst out_neg", 32'(out_neg), 32'd0);
      rst = 1'b0;

      // Directed table
      vecs.push_back('{16'h0047, 16'h0038, 1'b0, 0, 20'h00085, 1'b0, 1'b0});
      vecs.push_back('{16'h9999, 16'h0001, 1'b0, 0, 20'h10000, 1'b0, 1'b0});
      vecs.push_back('{16'h00A0, 16'h0001, 1'b0, 0, 20'h00000, 1'b1, 1'b0});
      vecs.push_back('{16'h1234, 16'h4321, 1'b0, 6, 20'h05555, 1'b0, 1'b0});
      vecs.push_back('{16'h0000, 16'h0000, 1'b0, 1, 20'h00000, 1'b0, 1'b0});
      vecs.push_back('{16'h9999, 16'h9999, 1'b0, 0, 20'h19998, 1'b0, 1'b0});
      vecs.push_back('{16'h5678, 16'h4444, 1'b0, 2, 20'h10122, 1'b0, 1'b0});
      vecs.push_back('{16'h0001, 16'hF000, 1'b0, 0, 20'h00000, 1'b1, 1'b0});
      if (SUB_EN) begin
         vecs.push_back('{16'h0003, 16'h0005, 1'b1, 0, 20'h09998, 1'b0, 1'b1});
         vecs.push_back('{16'h0005, 16'h0003, 1'b1, 0, 20'h00002, 1'b0, 1'b0});
         vecs.push_back('{16'h0000, 16'h0000, 1'b1, 0, 20'h00000, 1'b0, 1'b0});
         vecs.push_back('{16'h0000, 16'h9999, 1'b1, 3, 20'h00001, 1'b0, 1'b1});
         vecs.push_back('{16'h00A0, 16'h0001, 1'b1, 0, 20'h00000, 1'b1, 1'b0});
      end else begin
         vecs.push_back('{16'h0005, 16'h0003, 1'b1, 0, 20'h00008, 1'b0, 1'b0});
         vecs.push_back('{16'h0003, 16'h0009, 1'b1, 0, 20'h00012, 1'b0, 1'b0});
      end
      foreach (vecs[i]) begin
         run4(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].hold,
              vecs[i].sum, vecs[i].err, vecs[i].neg, $sformatf("vec%0d", i));
      end

      // Randomized operations against the reference model
      for (int k = 0; k < 40; k++) begin
         for (int d = 0; d < 4; d++) begin
            ra[4*d +: 4] = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            rb[4*d +: 4] = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
         end
         rs = 1'($urandom_range(0, 1));
         model(ra, rb, rs, es, ee, en);
         run4(ra, rb, rs, int'($urandom_range(0, 3)), es, ee, en, $sformatf("rnd%0d", k));
      end

      // Reset during RUN: leave a nonzero result behind, then abort an error op
      run4(16'h0047, 16'h0038, 1'b0, 0, 20'h00085, 1'b0, 1'b0, "pre_rst");
      @(negedge clk);
      in_a = 16'h00A0; in_b = 16'h0001; in_sub = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check("abort err latched", 32'(out_err), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort in_ready", 32'(in_ready), 32'd1);
      check("abort out_valid", 32'(out_valid), 32'd0);
      check("abort out_sum", 32'(out_sum), 32'd0);
      check("abort out_err", 32'(out_err), 32'd0);
      run4(16'h1234, 16'h4321, 1'b0, 0, 20'h05555, 1'b0, 1'b0, "post_rst");

      // Single-digit instance: exhaustive, back to back with out_ready tied high
      out_ready1 = 1'b1;
      in_valid1  = 1'b1;
      total = 0;
      for (int a = 0; a < 10; a++) begin
         for (int b = 0; b < 10; b++) begin
            n = 0;
            while (!in_ready1 && n < 20) begin
               @(negedge clk);
               n++;
            end
            in_a1 = 4'(a); in_b1 = 4'(b);
            @(negedge clk);
            t = 0;
            while (!out_valid1 && t < 20) begin
               @(negedge clk);
               t++;
            end
            total += n + 1 + t;
            check($sformatf("nd1 %0d+%0d sum", a, b), 32'(out_sum1),
                  32'(((a + b) / 10) * 16 + ((a + b) % 10)));
            check($sformatf("nd1 %0d+%0d err", a, b), 32'(out_err1), 32'd0);
         end
      end
      in_valid1 = 1'b0;
      check("nd1 throughput cycles", 32'(total), 32'd299);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
